// File: rtl/mem_stage_pkg.sv
// Shared constants for the load/store memory stage: funct3 encodings, exception codes, FSM states.
// Also holds the access-size decode used by the optional alignment check (MEM_STAGE_ALIGN_CHECK_EN).
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_RANGE    = 2'b10
    } exc_e;

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;
    localparam logic [2:0] F_SB  = 3'b000;
    localparam logic [2:0] F_SH  = 3'b001;
    localparam logic [2:0] F_SW  = 3'b010;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } req_t;

    // Undefined funct codes fall through to a word access.
    function automatic size_e access_size(input logic we, input logic [2:0] funct);
        access_size = SZ_WORD;
        if (we) begin
            case (funct)
                F_SB:    access_size = SZ_BYTE;
                F_SH:    access_size = SZ_HALF;
                default: access_size = SZ_WORD;
            endcase
        end else begin
            case (funct)
                F_LB, F_LBU: access_size = SZ_BYTE;
                F_LH, F_LHU: access_size = SZ_HALF;
                default:     access_size = SZ_WORD;
            endcase
        end
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/response handshake bus between the pipeline and the memory stage.
interface mem_stage_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_exc;

    modport master (
        output req_valid, req_we, req_funct, req_addr, req_wdata, req_rd, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_exc
    );

    modport slave (
        input  req_valid, req_we, req_funct, req_addr, req_wdata, req_rd, resp_ready,
        output req_ready, resp_valid, resp_data, resp_rd, resp_exc
    );
endinterface

// File: rtl/mem_stage.sv
// Load/store memory stage: IDLE -> ACCESS (WAIT_CYCLES+1) -> RESP, one request in flight.
// Define MEM_STAGE_ALIGN_CHECK_EN to flag misaligned half/word accesses instead of passing them through.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        n_rst,
    mem_stage_if.slave  bus,
    output logic [15:0] ram_rd_addr,
    output logic [2:0]  ram_rd_funct,
    input  logic [31:0] ram_rd_data,
    output logic        ram_wr_en,
    output logic [15:0] ram_wr_addr,
    output logic [31:0] ram_wr_data,
    output logic [2:0]  ram_wr_funct
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q;
    req_t        req_q;
    exc_e        exc;
    logic        accept, access_act, last_access;
    logic [31:0] resp_data_q;
    logic [4:0]  resp_rd_q;
    logic [1:0]  resp_exc_q;

    always_ff @(posedge clk) begin
        if (!n_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Handshake outputs are gated with n_rst so they read 0 while reset is held.
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        access_act     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = n_rst;
                if (bus.req_valid) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                access_act = n_rst;
                if (cnt_q == 4'd0) state_d = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = n_rst;
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept      = bus.req_valid && bus.req_ready;
    assign last_access = access_act && (cnt_q == 4'd0);

    // Out-of-range wins over misaligned.
    always_comb begin
        exc = EXC_NONE;
        if (req_q.addr[31:16] != 16'd0) begin
            exc = EXC_RANGE;
        end
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        else begin
            case (access_size(req_q.we, req_q.funct))
                SZ_HALF: if (req_q.addr[0])          exc = EXC_MISALIGN;
                SZ_WORD: if (req_q.addr[1:0] != 2'd0) exc = EXC_MISALIGN;
                default: ;
            endcase
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            req_q       <= '0;
            cnt_q       <= 4'd0;
            resp_data_q <= 32'd0;
            resp_rd_q   <= 5'd0;
            resp_exc_q  <= EXC_NONE;
        end else begin
            if (accept) begin
                req_q <= '{we: bus.req_we, funct: bus.req_funct, addr: bus.req_addr,
                           wdata: bus.req_wdata, rd: bus.req_rd};
                cnt_q <= WAIT_LD;
            end else if (access_act && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (last_access) begin
                resp_data_q <= (!req_q.we && exc == EXC_NONE) ? ram_rd_data : 32'd0;
                resp_rd_q   <= req_q.rd;
                resp_exc_q  <= exc;
            end
        end
    end

    assign bus.resp_data = resp_data_q;
    assign bus.resp_rd   = resp_rd_q;
    assign bus.resp_exc  = resp_exc_q;

    assign ram_rd_addr  = access_act ? req_q.addr[15:0] : 16'd0;
    assign ram_rd_funct = access_act ? req_q.funct      : 3'd0;
    assign ram_wr_addr  = access_act ? req_q.addr[15:0] : 16'd0;
    assign ram_wr_funct = access_act ? req_q.funct      : 3'd0;
    assign ram_wr_data  = access_act ? req_q.wdata      : 32'd0;
    assign ram_wr_en    = last_access && req_q.we && (exc == EXC_NONE);

endmodule
